// File: rtl/al4s3b_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter in front of the
// fabric register slave.
package al4s3b_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10,
        ST_TOUT = 2'b11
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam logic [31:0] DEF_READ_VALUE   = 32'hBAD_FAB_AC;
    localparam int          DEF_CNTR_WIDTH   = 3;
    localparam int          DEF_CNTR_TIMEOUT = 7;

endpackage

// File: rtl/al4s3b_wb_tout_cntr.sv
// ACK timeout counter: cleared on grant entry or slave ACK, saturates at the
// terminal count so it can never wrap back into a false "still waiting" value.
module al4s3b_wb_tout_cntr #(
    parameter int WIDTH   = 3,
    parameter int TIMEOUT = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TIMEOUT);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != TC_VAL)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/al4s3b_wb_arbiter.sv
// Round-robin Wishbone arbiter: AHB bridge (M0) and fabric sequencer (M1)
// share the register slave, with CYC lock and per-transfer ACK timeout.
//
// state | meaning
// IDLE  | no owner, slave bus driven to 0
// GNT0  | master 0 owns the slave
// GNT1  | master 1 owns the slave
// TOUT  | one cycle completing a timed-out transfer with the default read value
module al4s3b_wb_arbiter
    import al4s3b_arb_pkg::*;
#(
    parameter int          APERWIDTH            = 17,
    parameter logic [31:0] DEFAULT_READ_VALUE   = DEF_READ_VALUE,
    parameter int          DEFAULT_CNTR_WIDTH   = DEF_CNTR_WIDTH,
    parameter int          DEFAULT_CNTR_TIMEOUT = DEF_CNTR_TIMEOUT
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST,
    input  logic [APERWIDTH-1:0] M0_ADR,
    input  logic                 M0_CYC,
    input  logic                 M0_STB,
    input  logic                 M0_WE,
    input  logic [3:0]           M0_BYTE_STB,
    input  logic [31:0]          M0_WR_DAT,
    output logic [31:0]          M0_RD_DAT,
    output logic                 M0_ACK,
    input  logic [APERWIDTH-1:0] M1_ADR,
    input  logic                 M1_CYC,
    input  logic                 M1_STB,
    input  logic                 M1_WE,
    input  logic [3:0]           M1_BYTE_STB,
    input  logic [31:0]          M1_WR_DAT,
    output logic [31:0]          M1_RD_DAT,
    output logic                 M1_ACK,
    output logic [APERWIDTH-1:0] WBs_ADR,
    output logic                 WBs_CYC,
    output logic                 WBs_STB,
    output logic                 WBs_WE,
    output logic                 WBs_RD,
    output logic [3:0]           WBs_BYTE_STB,
    output logic [31:0]          WBs_WR_DAT,
    input  logic [31:0]          WBs_RD_DAT,
    input  logic                 WBs_ACK,
    input  logic [1:0]           Arb_Err_Clr,
    output logic [1:0]           Arb_Err_Sts,
    output logic [1:0]           Arb_Gnt
);

    arb_state_e state, state_nxt;
    logic       last_gnt;   // 1: M1 was granted most recently
    logic       cntr_tc;
    logic       cntr_clr;
    logic       cntr_inc;
    logic       timeout;
    logic       enter_gnt;
    logic [1:0] err_set;

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            state       <= ST_IDLE;
            last_gnt    <= 1'b1;
            Arb_Err_Sts <= 2'b00;
        end else begin
            state       <= state_nxt;
            Arb_Err_Sts <= (Arb_Err_Sts & ~Arb_Err_Clr) | err_set;
            if (state == ST_IDLE && state_nxt == ST_GNT0) last_gnt <= 1'b0;
            if (state == ST_IDLE && state_nxt == ST_GNT1) last_gnt <= 1'b1;
        end
    end

    assign cntr_inc = WBs_STB & ~WBs_ACK;
    assign timeout  = cntr_tc & cntr_inc;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (M0_CYC && M1_CYC) state_nxt = last_gnt ? ST_GNT0 : ST_GNT1;
                else if (M0_CYC)      state_nxt = ST_GNT0;
                else if (M1_CYC)      state_nxt = ST_GNT1;
            end
            ST_GNT0: begin
                if (!M0_CYC)      state_nxt = ST_IDLE;
                else if (timeout) state_nxt = ST_TOUT;
            end
            ST_GNT1: begin
                if (!M1_CYC)      state_nxt = ST_IDLE;
                else if (timeout) state_nxt = ST_TOUT;
            end
            ST_TOUT: begin
                if (last_gnt) state_nxt = M1_CYC ? ST_GNT1 : ST_IDLE;
                else          state_nxt = M0_CYC ? ST_GNT0 : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign enter_gnt  = ((state_nxt == ST_GNT0) || (state_nxt == ST_GNT1)) && (state_nxt != state);
    assign cntr_clr   = enter_gnt | WBs_ACK;
    assign err_set[0] = (state == ST_GNT0) && (state_nxt == ST_TOUT);
    assign err_set[1] = (state == ST_GNT1) && (state_nxt == ST_TOUT);

    always_comb begin
        WBs_ADR      = '0;
        WBs_CYC      = 1'b0;
        WBs_STB      = 1'b0;
        WBs_WE       = 1'b0;
        WBs_BYTE_STB = 4'h0;
        WBs_WR_DAT   = 32'h0;
        M0_ACK       = 1'b0;
        M0_RD_DAT    = 32'h0;
        M1_ACK       = 1'b0;
        M1_RD_DAT    = 32'h0;
        Arb_Gnt      = GNT_NONE;
        case (state)
            ST_GNT0: begin
                WBs_ADR      = M0_ADR;
                WBs_CYC      = M0_CYC;
                WBs_STB      = M0_STB;
                WBs_WE       = M0_WE;
                WBs_BYTE_STB = M0_BYTE_STB;
                WBs_WR_DAT   = M0_WR_DAT;
                M0_ACK       = WBs_ACK;
                M0_RD_DAT    = WBs_RD_DAT;
                Arb_Gnt      = GNT_M0;
            end
            ST_GNT1: begin
                WBs_ADR      = M1_ADR;
                WBs_CYC      = M1_CYC;
                WBs_STB      = M1_STB;
                WBs_WE       = M1_WE;
                WBs_BYTE_STB = M1_BYTE_STB;
                WBs_WR_DAT   = M1_WR_DAT;
                M1_ACK       = WBs_ACK;
                M1_RD_DAT    = WBs_RD_DAT;
                Arb_Gnt      = GNT_M1;
            end
            ST_TOUT: begin
                if (last_gnt) begin
                    M1_ACK    = 1'b1;
                    M1_RD_DAT = DEFAULT_READ_VALUE;
                end else begin
                    M0_ACK    = 1'b1;
                    M0_RD_DAT = DEFAULT_READ_VALUE;
                end
            end
            default: ;
        endcase
    end

    assign WBs_RD = WBs_CYC & WBs_STB & ~WBs_WE;

    al4s3b_wb_tout_cntr #(
        .WIDTH   (DEFAULT_CNTR_WIDTH),
        .TIMEOUT (DEFAULT_CNTR_TIMEOUT)
    ) u_tout_cntr (
        .clk (WB_CLK),
        .rst (WB_RST),
        .clr (cntr_clr),
        .inc (cntr_inc),
        .tc  (cntr_tc)
    );

endmodule

// File: tb/tb_al4s3b_wb_arbiter.sv
// Directed bench for the two-master Wishbone arbiter: read, tie-break, lock,
// timeout with sticky error, and reset mid-transfer.
module tb_al4s3b_wb_arbiter;

    logic        WB_CLK = 1'b0;
    logic        WB_RST;
    logic [16:0] M0_ADR, M1_ADR;
    logic        M0_CYC, M0_STB, M0_WE, M1_CYC, M1_STB, M1_WE;
    logic [3:0]  M0_BYTE_STB, M1_BYTE_STB;
    logic [31:0] M0_WR_DAT, M1_WR_DAT;
    logic [31:0] M0_RD_DAT, M1_RD_DAT;
    logic        M0_ACK, M1_ACK;
    logic [16:0] WBs_ADR;
    logic        WBs_CYC, WBs_STB, WBs_WE, WBs_RD;
    logic [3:0]  WBs_BYTE_STB;
    logic [31:0] WBs_WR_DAT;
    logic [31:0] WBs_RD_DAT;
    logic        WBs_ACK;
    logic [1:0]  Arb_Err_Clr, Arb_Err_Sts, Arb_Gnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 WB_CLK = ~WB_CLK;

    al4s3b_wb_arbiter dut (
        .WB_CLK(WB_CLK), .WB_RST(WB_RST),
        .M0_ADR(M0_ADR), .M0_CYC(M0_CYC), .M0_STB(M0_STB), .M0_WE(M0_WE),
        .M0_BYTE_STB(M0_BYTE_STB), .M0_WR_DAT(M0_WR_DAT), .M0_RD_DAT(M0_RD_DAT), .M0_ACK(M0_ACK),
        .M1_ADR(M1_ADR), .M1_CYC(M1_CYC), .M1_STB(M1_STB), .M1_WE(M1_WE),
        .M1_BYTE_STB(M1_BYTE_STB), .M1_WR_DAT(M1_WR_DAT), .M1_RD_DAT(M1_RD_DAT), .M1_ACK(M1_ACK),
        .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC), .WBs_STB(WBs_STB), .WBs_WE(WBs_WE), .WBs_RD(WBs_RD),
        .WBs_BYTE_STB(WBs_BYTE_STB), .WBs_WR_DAT(WBs_WR_DAT), .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK),
        .Arb_Err_Clr(Arb_Err_Clr), .Arb_Err_Sts(Arb_Err_Sts), .Arb_Gnt(Arb_Gnt)
    );

    task automatic tick();
        @(posedge WB_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        WB_RST = 1'b1;
        M0_ADR = '0; M0_CYC = 0; M0_STB = 0; M0_WE = 0; M0_BYTE_STB = 4'h0; M0_WR_DAT = '0;
        M1_ADR = '0; M1_CYC = 0; M1_STB = 0; M1_WE = 0; M1_BYTE_STB = 4'h0; M1_WR_DAT = '0;
        WBs_RD_DAT = '0; WBs_ACK = 0; Arb_Err_Clr = 2'b00;
        tick(); tick(); tick();
        WB_RST = 1'b0;

        chk("rst_gnt", 32'(Arb_Gnt), 32'h0);
        chk("rst_wbs_cyc", 32'(WBs_CYC), 32'h0);
        chk("rst_err", 32'(Arb_Err_Sts), 32'h0);
        chk("rst_m0_ack", 32'(M0_ACK), 32'h0);
        chk("rst_m0_rd", M0_RD_DAT, 32'h0);

        // Single M0 read, slave ACKs in the third granted cycle
        M0_CYC = 1; M0_STB = 1; M0_ADR = 17'h00014; M0_BYTE_STB = 4'hF;
        chk("rd_gnt_pre", 32'(Arb_Gnt), 32'h0);
        tick();
        chk("rd_gnt", 32'(Arb_Gnt), 32'h1);
        chk("rd_wbs_cyc", 32'(WBs_CYC), 32'h1);
        chk("rd_wbs_adr", 32'(WBs_ADR), 32'h14);
        chk("rd_wbs_rd", 32'(WBs_RD), 32'h1);
        tick();
        chk("rd_m0_ack_wait", 32'(M0_ACK), 32'h0);
        tick();
        WBs_ACK = 1; WBs_RD_DAT = 32'h0000_0005;
        #1;
        chk("rd_m0_ack", 32'(M0_ACK), 32'h1);
        chk("rd_m0_dat", M0_RD_DAT, 32'h5);
        chk("rd_m1_ack", 32'(M1_ACK), 32'h0);
        chk("rd_m1_dat", M1_RD_DAT, 32'h0);
        tick();
        WBs_ACK = 0; WBs_RD_DAT = '0; M0_CYC = 0; M0_STB = 0;
        tick();
        chk("rd_idle", 32'(Arb_Gnt), 32'h0);

        // Simultaneous requests right after reset: M0 first, dead cycle, then M1
        WB_RST = 1; tick(); WB_RST = 0;
        M0_CYC = 1; M1_CYC = 1;
        tick();
        chk("tie_m0", 32'(Arb_Gnt), 32'h1);
        M0_CYC = 0;
        tick();
        chk("tie_dead", 32'(Arb_Gnt), 32'h0);
        tick();
        chk("tie_m1", 32'(Arb_Gnt), 32'h2);

        // Lock: M1 keeps CYC over three single-cycle writes while M0 waits
        M0_CYC = 1;
        M1_WE = 1; M1_STB = 1; M1_ADR = 17'h00008; M1_BYTE_STB = 4'hF;
        for (int i = 0; i < 3; i++) begin
            M1_WR_DAT = 32'hA000_0000 + 32'(i);
            WBs_ACK = 1;
            #1;
            chk("lock_gnt", 32'(Arb_Gnt), 32'h2);
            chk("lock_we", 32'(WBs_WE), 32'h1);
            chk("lock_rd", 32'(WBs_RD), 32'h0);
            chk("lock_adr", 32'(WBs_ADR), 32'h8);
            chk("lock_wdat", WBs_WR_DAT, 32'hA000_0000 + 32'(i));
            chk("lock_m1_ack", 32'(M1_ACK), 32'h1);
            chk("lock_m0_ack", 32'(M0_ACK), 32'h0);
            tick();
        end
        M1_STB = 0; M1_CYC = 0; M1_WE = 0; WBs_ACK = 0;
        #1;
        chk("lock_hold", 32'(Arb_Gnt), 32'h2);
        tick();
        chk("lock_dead", 32'(Arb_Gnt), 32'h0);
        tick();
        chk("lock_m0_gnt", 32'(Arb_Gnt), 32'h1);
        M0_CYC = 0;
        tick();

        // Timeout: M1 read never acknowledged
        M1_CYC = 1; M1_STB = 1; M1_ADR = 17'h00010;
        tick();
        for (int i = 1; i <= 8; i++) begin
            chk("to_wait_ack", 32'(M1_ACK), 32'h0);
            tick();
        end
        chk("to_m1_ack", 32'(M1_ACK), 32'h1);
        chk("to_m1_dat", M1_RD_DAT, 32'hBAD_FAB_AC);
        chk("to_err", 32'(Arb_Err_Sts), 32'h2);
        chk("to_wbs_cyc", 32'(WBs_CYC), 32'h0);
        chk("to_m0_ack", 32'(M0_ACK), 32'h0);
        M1_CYC = 0; M1_STB = 0;
        tick();
        chk("to_m1_ack_off", 32'(M1_ACK), 32'h0);
        chk("to_err_sticky", 32'(Arb_Err_Sts), 32'h2);
        Arb_Err_Clr = 2'b10;
        tick();
        Arb_Err_Clr = 2'b00;
        chk("to_err_clr", 32'(Arb_Err_Sts), 32'h0);

        // Reset while M0 has a pending strobe
        M0_CYC = 1; M0_STB = 1; M0_ADR = 17'h00004;
        tick();
        chk("rm_gnt", 32'(Arb_Gnt), 32'h1);
        chk("rm_stb", 32'(WBs_STB), 32'h1);
        WB_RST = 1;
        tick();
        chk("rm_wbs_cyc", 32'(WBs_CYC), 32'h0);
        chk("rm_wbs_stb", 32'(WBs_STB), 32'h0);
        chk("rm_wbs_adr", 32'(WBs_ADR), 32'h0);
        chk("rm_gnt0", 32'(Arb_Gnt), 32'h0);
        chk("rm_m0_ack", 32'(M0_ACK), 32'h0);
        WB_RST = 0; M1_CYC = 1;
        tick();
        chk("rm_tie_m0", 32'(Arb_Gnt), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
